// File: rtl/wb_arbiter_if.sv
// Bus bundle for the write-back arbiter: three result sources, the register-file
// write port, the forwarding lookup and the occupancy count.
interface wb_arbiter_if #(
    parameter int DEPTH = 4
) ();
    localparam int CW = $clog2(DEPTH) + 1;

    logic        mem_valid, mul_valid, alu_valid;
    logic [4:0]  mem_rd, mul_rd, alu_rd;
    logic [31:0] mem_data, mul_data, alu_data;
    logic        mem_ready, mul_ready, alu_ready;

    logic [4:0]  wt_addr;
    logic [31:0] wt_data;
    logic        l_s;

    logic [4:0]  fwd_addr;
    logic        fwd_hit;
    logic [31:0] fwd_data;

    logic [CW-1:0] count;

    modport slave (
        input  mem_valid, mul_valid, alu_valid,
        input  mem_rd, mul_rd, alu_rd,
        input  mem_data, mul_data, alu_data,
        output mem_ready, mul_ready, alu_ready,
        output wt_addr, wt_data, l_s,
        input  fwd_addr,
        output fwd_hit, fwd_data,
        output count
    );

    modport master (
        output mem_valid, mul_valid, alu_valid,
        output mem_rd, mul_rd, alu_rd,
        output mem_data, mul_data, alu_data,
        input  mem_ready, mul_ready, alu_ready,
        input  wt_addr, wt_data, l_s,
        output fwd_addr,
        input  fwd_hit, fwd_data,
        input  count
    );
endinterface

// File: rtl/wb_arbiter.sv
// Write-back arbiter: accepts up to two results per cycle (mem > mul > alu) into an
// in-order queue and retires one per cycle to the register file. Optional forwarding
// lookup is enabled with the WB_FWD_EN macro.
module wb_arbiter #(
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    wb_arbiter_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [4:0]    q_rd   [DEPTH];
    logic [31:0]   q_data [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count_q;

    logic [4:0]    wt_addr_q;
    logic [31:0]   wt_data_q;
    logic          l_s_q;

    logic [2:0]    src_valid;
    logic [4:0]    src_rd   [3];
    logic [31:0]   src_data [3];
    logic [2:0]    gnt;

    logic [CW-1:0] free;
    logic          two_ok;
    logic          pop;
    logic [1:0]    n_push;
    logic [4:0]    push_rd   [2];
    logic [31:0]   push_data [2];

    assign src_valid   = {bus.alu_valid, bus.mul_valid, bus.mem_valid};
    assign src_rd[0]   = bus.mem_rd;
    assign src_rd[1]   = bus.mul_rd;
    assign src_rd[2]   = bus.alu_rd;
    assign src_data[0] = bus.mem_data;
    assign src_data[1] = bus.mul_data;
    assign src_data[2] = bus.alu_data;

    // The head always pops when non-empty, so a full queue still has one slot.
    assign free   = CW'(DEPTH) - count_q + CW'(count_q != '0);
    assign two_ok = (free >= CW'(2));
    assign pop    = (count_q != '0);

    always_comb begin
        gnt    = '0;
        gnt[0] = src_valid[0];
        gnt[1] = src_valid[1] && (!src_valid[0] || two_ok);
        gnt[2] = src_valid[2] &&
                 (!(src_valid[0] || src_valid[1]) ||
                  ((src_valid[0] ^ src_valid[1]) && two_ok));
        if (rst) begin
            gnt = '0;
        end
    end

    assign bus.mem_ready = gnt[0];
    assign bus.mul_ready = gnt[1];
    assign bus.alu_ready = gnt[2];

    // Pack kept grants in priority order; rd=0 results are handshaken but dropped.
    always_comb begin
        n_push    = 2'd0;
        push_rd   = '{default: '0};
        push_data = '{default: '0};
        for (int i = 0; i < 3; i++) begin
            if (gnt[i] && (src_rd[i] != 5'd0)) begin
                push_rd[n_push[0]]   = src_rd[i];
                push_data[n_push[0]] = src_data[i];
                n_push               = n_push + 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count_q   <= '0;
            wt_addr_q <= '0;
            wt_data_q <= '0;
            l_s_q     <= 1'b0;
        end else begin
            l_s_q <= pop;
            if (pop) begin
                wt_addr_q <= q_rd[rd_ptr];
                wt_data_q <= q_data[rd_ptr];
                rd_ptr    <= rd_ptr + PW'(1);
            end
            wr_ptr  <= wr_ptr + PW'(n_push);
            count_q <= count_q + CW'(n_push) - CW'(pop);
        end
    end

    // Storage needs no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (n_push != 2'd0) begin
            q_rd[wr_ptr]   <= push_rd[0];
            q_data[wr_ptr] <= push_data[0];
        end
        if (n_push == 2'd2) begin
            q_rd[wr_ptr + PW'(1)]   <= push_rd[1];
            q_data[wr_ptr + PW'(1)] <= push_data[1];
        end
    end

    assign bus.wt_addr = wt_addr_q;
    assign bus.wt_data = wt_data_q;
    assign bus.l_s     = l_s_q;
    assign bus.count   = count_q;

`ifdef WB_FWD_EN
    logic          fwd_hit_c;
    logic [31:0]   fwd_data_c;
    logic [PW-1:0] idx;

    // Scan oldest to youngest so the last match found is the youngest.
    always_comb begin
        fwd_hit_c  = 1'b0;
        fwd_data_c = '0;
        idx        = '0;
        if (bus.fwd_addr != 5'd0) begin
            if (l_s_q && (wt_addr_q == bus.fwd_addr)) begin
                fwd_hit_c  = 1'b1;
                fwd_data_c = wt_data_q;
            end
            for (int i = 0; i < DEPTH; i++) begin
                idx = rd_ptr + PW'(i);
                if ((CW'(i) < count_q) && (q_rd[idx] == bus.fwd_addr)) begin
                    fwd_hit_c  = 1'b1;
                    fwd_data_c = q_data[idx];
                end
            end
        end
    end

    assign bus.fwd_hit  = fwd_hit_c;
    assign bus.fwd_data = fwd_data_c;
`else
    logic unused_fwd;
    assign unused_fwd   = ^bus.fwd_addr;
    assign bus.fwd_hit  = 1'b0;
    assign bus.fwd_data = '0;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: accepted results are queued as expected writes and
// retired against l_s/wt_addr/wt_data; readys, count and forwarding are checked each cycle.
module tb_wb_arbiter;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  v = '0;
    logic [4:0]  r [3] = '{default: '0};
    logic [31:0] d [3] = '{default: '0};
    logic [4:0]  fa = '0;

    ent_t        sb [$];
    logic        exp_ls = 1'b0;
    logic [4:0]  exp_wa = '0;
    logic [31:0] exp_wd = '0;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    wb_arbiter_if #(.DEPTH(DEPTH)) bus ();

    assign bus.mem_valid = v[0];
    assign bus.mul_valid = v[1];
    assign bus.alu_valid = v[2];
    assign bus.mem_rd    = r[0];
    assign bus.mul_rd    = r[1];
    assign bus.alu_rd    = r[2];
    assign bus.mem_data  = d[0];
    assign bus.mul_data  = d[1];
    assign bus.alu_data  = d[2];
    assign bus.fwd_addr  = fa;

    wb_arbiter #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic req(input int src, input logic [4:0] rd, input logic [31:0] data);
        v[src] = 1'b1;
        r[src] = rd;
        d[src] = data;
    endtask

    // One clock: check readys and forwarding before the edge, retire/enqueue in the
    // scoreboard across it, then check the registered outputs.
    task automatic step();
        int   cnt, free, lim, taken;
        logic eg [3];
        logic exp_hit;
        logic [31:0] exp_fd;
        ent_t e;

        @(negedge clk);
        cnt   = sb.size();
        free  = DEPTH - cnt + ((cnt != 0) ? 1 : 0);
        lim   = (free < 2) ? free : 2;
        taken = 0;
        for (int i = 0; i < 3; i++) begin
            eg[i] = !rst && v[i] && (taken < lim);
            if (eg[i]) taken++;
        end
        chk("mem_ready", {31'd0, bus.mem_ready}, {31'd0, eg[0]});
        chk("mul_ready", {31'd0, bus.mul_ready}, {31'd0, eg[1]});
        chk("alu_ready", {31'd0, bus.alu_ready}, {31'd0, eg[2]});

        exp_hit = 1'b0;
        exp_fd  = '0;
`ifdef WB_FWD_EN
        if (fa != 5'd0) begin
            if (exp_ls && exp_wa == fa) begin
                exp_hit = 1'b1;
                exp_fd  = exp_wd;
            end
            foreach (sb[k]) begin
                if (sb[k].rd == fa) begin
                    exp_hit = 1'b1;
                    exp_fd  = sb[k].data;
                end
            end
        end
`endif
        chk("fwd_hit", {31'd0, bus.fwd_hit}, {31'd0, exp_hit});
        chk("fwd_data", bus.fwd_data, exp_fd);

        @(posedge clk);
        #1;
        if (rst) begin
            sb.delete();
            exp_ls = 1'b0;
            exp_wa = '0;
            exp_wd = '0;
        end else begin
            if (sb.size() != 0) begin
                e      = sb.pop_front();
                exp_ls = 1'b1;
                exp_wa = e.rd;
                exp_wd = e.data;
            end else begin
                exp_ls = 1'b0;
            end
            for (int i = 0; i < 3; i++) begin
                if (eg[i]) begin
                    if (r[i] != 5'd0) sb.push_back('{rd: r[i], data: d[i]});
                    v[i] = 1'b0;
                end
            end
        end
        chk("l_s", {31'd0, bus.l_s}, {31'd0, exp_ls});
        chk("wt_addr", {27'd0, bus.wt_addr}, {27'd0, exp_wa});
        chk("wt_data", bus.wt_data, exp_wd);
        chk("count", {29'd0, bus.count}, sb.size());
    endtask

    task automatic drain();
        for (int k = 0; k < 30; k++) begin
            if (v == 3'b000 && sb.size() == 0) break;
            step();
        end
        chk("drain_done", sb.size() + int'(v != 3'b000), 0);
        step();
    endtask

    initial begin
        logic        e_hit;
        logic [31:0] e_dat;

        // Reset held with every source valid.
        rst = 1'b1;
        req(0, 5'd1, 32'h101);
        req(1, 5'd2, 32'h202);
        req(2, 5'd4, 32'h404);
        step();
        step();
        chk("rst_count", {29'd0, bus.count}, 0);
        chk("rst_l_s", {31'd0, bus.l_s}, 0);
        rst = 1'b0;
        drain();

        // Three-way contention.
        fa = 5'd6;
        req(0, 5'd5, 32'h11);
        req(1, 5'd6, 32'h22);
        req(2, 5'd7, 32'h33);
        step();
        chk("contend_alu_wait", {31'd0, v[2]}, 1);
        drain();

        // Two sources every cycle until the queue saturates.
        fa = 5'd21;
        for (int c = 0; c < 8; c++) begin
            if (!v[0]) req(0, 5'(20 + c), 32'hA000 + c);
            if (!v[1]) req(1, 5'(21 + c), 32'hB000 + c);
            step();
        end
        chk("full_count", {29'd0, bus.count}, DEPTH);
        drain();

        // rd=0 is accepted but never written.
        req(2, 5'd0, 32'hDEAD);
        req(0, 5'd3, 32'h1);
        step();
        chk("rd0_count", {29'd0, bus.count}, 1);
        drain();

        // Forwarding of the youngest pending value.
        fa = 5'd9;
        req(0, 5'd9, 32'hA);
        step();
        req(0, 5'd9, 32'hB);
        step();
`ifdef WB_FWD_EN
        e_hit = 1'b1;
        e_dat = 32'hB;
`else
        e_hit = 1'b0;
        e_dat = 32'h0;
`endif
        chk("fwd_young_hit", {31'd0, bus.fwd_hit}, {31'd0, e_hit});
        chk("fwd_young_data", bus.fwd_data, e_dat);
        drain();
        chk("fwd_drained_hit", {31'd0, bus.fwd_hit}, 0);
        fa = 5'd0;
        #1;
        chk("fwd_x0_hit", {31'd0, bus.fwd_hit}, 0);

        // Reset with three entries queued.
        req(0, 5'd10, 32'hC10);
        req(1, 5'd11, 32'hC11);
        step();
        req(0, 5'd12, 32'hC12);
        req(1, 5'd13, 32'hC13);
        step();
        chk("pre_rst_count", {29'd0, bus.count}, 3);
        rst = 1'b1;
        v   = '0;
        step();
        rst = 1'b0;
        step();
        chk("post_rst_l_s", {31'd0, bus.l_s}, 0);
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1);
    end
endmodule
